// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers BCD digits from a multiplexed active-low
// 7-seg bus (seg, an) and hands out 8-digit frames on frame_valid/ready.
// Ports: clk, rst_n | seg[6:0], an[7:0] in | frame_data[31:0],
//   frame_err[7:0], frame_valid out, frame_ready in | overrun, bus_err
//   sticky out, clr_err in.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] frame_data,
    output logic [7:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun,
    output logic        bus_err,
    input  logic        clr_err
);

    typedef enum logic {
        WAIT,
        HOLD
    } state_t;

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [6:0]  r_seg;
    logic [7:0]  r_an;
    logic [7:0]  cnt;
    logic [7:0]  mask;
    logic [31:0] store;
    logic [7:0]  store_err;

    logic        match;
    logic        cap;
    logic [7:0]  an_low;
    logic        an_none;
    logic        an_multi;
    logic        dig_wr;
    logic        bus_set;
    logic        full;
    logic        ovr_set;
    logic        load;
    logic [3:0]  nib;
    logic        nib_err;

    assign match   = (seg == r_seg) && (an == r_an);
    assign an_low  = ~an;
    assign an_none = (an == 8'hFF);
    // x & (x-1) is nonzero exactly when more than one bit is set
    assign an_multi = |(an_low & (an_low - 8'd1));
    assign dig_wr  = cap && !an_none && !an_multi;
    assign bus_set = cap && an_multi;
    assign full    = (mask == 8'hFF);
    assign load    = full && (!frame_valid || frame_ready);
    assign ovr_set = full && frame_valid && !frame_ready;

    always_comb begin
        nib     = 4'hE;
        nib_err = 1'b1;
        case (seg)
            7'b0000001: begin nib = 4'h0; nib_err = 1'b0; end
            7'b1001111: begin nib = 4'h1; nib_err = 1'b0; end
            7'b0010010: begin nib = 4'h2; nib_err = 1'b0; end
            7'b0000110: begin nib = 4'h3; nib_err = 1'b0; end
            7'b1001100: begin nib = 4'h4; nib_err = 1'b0; end
            7'b0100100: begin nib = 4'h5; nib_err = 1'b0; end
            7'b0100000: begin nib = 4'h6; nib_err = 1'b0; end
            7'b0001111: begin nib = 4'h7; nib_err = 1'b0; end
            7'b0000000: begin nib = 4'h8; nib_err = 1'b0; end
            7'b0000100: begin nib = 4'h9; nib_err = 1'b0; end
            7'b1111110: begin nib = 4'hF; nib_err = 1'b0; end
            default:    begin nib = 4'hE; nib_err = 1'b1; end
        endcase
    end

    // state register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            cnt   <= '0;
            r_seg <= 7'h7F;
            r_an  <= 8'hFF;
        end else begin
            state <= state_nx;
            r_seg <= seg;
            r_an  <= an;
            if (!match) begin
                cnt <= '0;
            end else if (state == WAIT && cnt < LAST) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // next state
    always_comb begin
        state_nx = state;
        if (!match) begin
            state_nx = WAIT;
        end else if (state == WAIT && cnt == LAST) begin
            state_nx = HOLD;
        end
    end

    // capture strobe: one per stable window
    always_comb begin
        cap = 1'b0;
        if (match && state == WAIT && cnt == LAST) begin
            cap = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            store     <= '0;
            store_err <= '0;
        end else begin
            mask <= (full ? 8'h00 : mask) | (dig_wr ? an_low : 8'h00);
            for (int i = 0; i < 8; i++) begin
                if (dig_wr && an_low[i]) begin
                    store[4*i +: 4] <= nib;
                    store_err[i]    <= nib_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
        end else if (load) begin
            frame_data  <= store;
            frame_err   <= store_err;
            frame_valid <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // sticky flags: a set in the same cycle beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (bus_set) begin
                bus_err <= 1'b1;
            end else if (clr_err) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reads the far end of a multiplexed 8-digit, active-low 7-segment display bus (seg, an) and recovers one BCD nibble per digit.
- Used for loopback checking of the BCD-to-7-segment driver path and for display-bus monitoring.
- Each pattern is debounced for a fixed stability window, decoded back to BCD, and stored per digit.
- When all 8 digits have been captured, it emits a complete frame through a valid/ready handshake.

Parameters:
- STABLE_CYCLES, 4: consecutive matching clock edges required before a pattern is captured; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment bus {a,b,c,d,e,f,g}, active-low (0 = lit); synchronous to clk.
- an  input  8  anode selects, active-low; an[i]=0 selects digit i.
- frame_data  output  32  captured frame; digit i at [4i+3:4i].
- frame_err  output  8  per-digit flag; 1 = pattern was not a legal glyph.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts the frame.
- overrun  output  1  sticky; a frame completed while the previous one was still pending.
- bus_err  output  1  sticky; a stable an value had more than one bit low.
- clr_err  input  1  synchronous clear of overrun and bus_err.

Behaviour:
- Reset values:
  - frame_data=0, frame_err=0, frame_valid=0, overrun=0, bus_err=0.
  - Internal sample registers: r_seg=7'h7F, r_an=8'hFF; counter=0; capture mask=0; state WAIT.
- Sampling:
  - Every edge: r_seg<=seg, r_an<=an.
  - match = ({seg,an}=={r_seg,r_an}).
- FSM, states WAIT and HOLD:
  - match=0 (any state): counter<=0, state<=WAIT.
  - WAIT, match=1, counter<STABLE_CYCLES-1: counter++.
  - WAIT, match=1, counter==STABLE_CYCLES-1: evaluate capture, state<=HOLD.
  - HOLD: no further capture until match=0. One capture per stable window, so a static bus captures exactly once.
- Capture evaluation:
  - an==8'hFF (blank): no action.
  - Exactly one an bit low (index i): write digit i, set mask[i].
  - More than one bit low: bus_err<=1; no write.
- Decode table (seg -> nibble, err):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4.
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - 1111110 (dash) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- Re-capture of a digit already in the mask overwrites its nibble and err.
- Frame completion:
  - When mask becomes 8'hFF, frame_valid asserts on the next edge and mask clears to 0.
  - frame_data/frame_err are loaded from the internal digit store at that same edge.
- Handshake:
  - frame_data and frame_err stay stable while frame_valid=1.
  - frame_valid clears on the edge where frame_valid&&frame_ready.
  - Completion on the same edge as acceptance: new frame loads, frame_valid stays 1.
  - Completion while frame_valid=1 and frame_ready=0: new frame discarded, old frame kept, overrun<=1, mask still clears.
- Latency: input held constant from edge t is captured at edge t+STABLE_CYCLES. The frame appears one edge after the 8th capture.
- Errors: clr_err clears both sticky bits; a same-cycle set wins over clr_err.
- Reset mid-scan: discards mask, digit store, pending frame and sticky flags immediately.

Test Plan:
- Static bus: seg=0000110, an=01111111 held for 50 cycles -> exactly one capture (digit 7 = 3), mask=8'h80, frame_valid stays 0.
- Full scan: digits 0..7 driven with values 1..8, each held STABLE_CYCLES+2 cycles, frame_ready=1 -> one frame_valid pulse, frame_data=32'h87654321, frame_err=0.
- Glitch: pattern held STABLE_CYCLES-1 cycles, then changed -> no capture. Dash held on digit 2 -> nibble F, err=0. seg=1111111 on digit 3 -> nibble E, frame_err[3]=1.
- Backpressure: frame_ready=0 across two complete scans -> first frame stays stable, overrun=1. Then frame_ready=1 -> first frame accepted, frame_valid=0. clr_err -> overrun=0.
- Bus fault: an=8'b11110011 stable -> bus_err=1, no mask change. an=8'hFF stable -> no action.
- Reset mid-scan: rst_n low after 5 digits captured -> all outputs 0. A following full scan completes with the correct frame.
